// File: rtl/sobol_pkg.sv
// Shared types and direction-vector slicing helpers for the dual-channel Sobol generator.
// Helpers work on a fixed maximum width; callers take the top WIDTH bits of the result.
package sobol_pkg;

    typedef enum logic {
        SOBOL_IDLE,
        SOBOL_RUN
    } sobol_state_e;

    localparam int SOBOL_MAXW = 32;

    // Channel 0: word is the merged entry left-aligned in MAXW+1 bits; keep its top k+1 bits.
    function automatic logic [SOBOL_MAXW-1:0] dv_ch0(input logic [SOBOL_MAXW:0] word, input int k);
        logic [SOBOL_MAXW-1:0] m;
        m = ~({SOBOL_MAXW{1'b1}} >> (k + 1));
        return word[SOBOL_MAXW:1] & m;
    endfunction

    // Channel 1: word is the merged entry right-aligned; bits [k:0] move to the top.
    function automatic logic [SOBOL_MAXW-1:0] dv_ch1(input logic [SOBOL_MAXW:0] word, input int k);
        logic [SOBOL_MAXW-1:0] m;
        m = ~({SOBOL_MAXW{1'b1}} << (k + 1));
        return (word[SOBOL_MAXW-1:0] & m) << (SOBOL_MAXW - 1 - k);
    endfunction

endpackage

// File: rtl/sobol_lsz_idx.sv
// Trailing-ones encoder: position of the least-significant zero of cnt; MSB set when cnt is all ones.
module sobol_lsz_idx #(
    parameter int WIDTH    = 8,
    parameter int LOGWIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]  cnt,
    output logic [LOGWIDTH:0] idx
);

    always_comb begin
        idx = {1'b1, {LOGWIDTH{1'b0}}};
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!cnt[i]) idx = (LOGWIDTH + 1)'(i);
        end
    end

endmodule

// File: rtl/sobol_rng_pair.sv
// Dual-channel Sobol sequence source sharing one merged direction-vector register file.
// Gray-code style stepping: each sample XORs in the vector selected by the counter's trailing ones.
module sobol_rng_pair
    import sobol_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int LOGWIDTH = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                clr,
    input  logic                en,
    input  logic                cont,
    input  logic                dv_we,
    input  logic [LOGWIDTH-1:0] dv_addr,
    input  logic [WIDTH:0]      dv_wdata,
    output logic [WIDTH-1:0]    out0,
    output logic [WIDTH-1:0]    out1,
    output logic                out_valid,
    output logic                busy,
    output logic                done
);

    sobol_state_e        state;
    logic [WIDTH-1:0]    cnt;
    logic [WIDTH:0]      dv [WIDTH];
    logic [LOGWIDTH:0]   idx;
    logic                wrap;
    logic [LOGWIDTH-1:0] c;
    logic [LOGWIDTH-1:0] c1;
    logic [WIDTH-1:0]    v0;
    logic [WIDTH-1:0]    v1;
    logic                dv_ok;

    sobol_lsz_idx #(.WIDTH(WIDTH), .LOGWIDTH(LOGWIDTH)) u_idx (
        .cnt(cnt),
        .idx(idx)
    );

    assign wrap = idx[LOGWIDTH];
    assign c    = idx[LOGWIDTH-1:0];
    assign c1   = LOGWIDTH'(WIDTH - 1) - c;
    assign busy = out_valid;

    always_comb begin
        logic [SOBOL_MAXW-1:0] t0;
        logic [SOBOL_MAXW-1:0] t1;
        t0 = dv_ch0((SOBOL_MAXW + 1)'(dv[c]) << (SOBOL_MAXW - WIDTH), int'(c));
        t1 = dv_ch1((SOBOL_MAXW + 1)'(dv[c1]), int'(c));
        v0 = t0[SOBOL_MAXW-1 -: WIDTH];
        v1 = t1[SOBOL_MAXW-1 -: WIDTH];
    end

    // Table is only writable while idle so a running period sees a stable set of vectors.
    assign dv_ok = (state == SOBOL_IDLE) && dv_we && (int'(dv_addr) < WIDTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) dv[i] <= '0;
        end else if (dv_ok) begin
            dv[dv_addr] <= dv_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SOBOL_IDLE;
            cnt       <= '0;
            out0      <= '0;
            out1      <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else if (clr) begin
            state     <= SOBOL_IDLE;
            cnt       <= '0;
            out0      <= '0;
            out1      <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                SOBOL_IDLE: begin
                    if (start) begin
                        state     <= SOBOL_RUN;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        out0      <= '0;
                        out1      <= '0;
                    end
                end
                SOBOL_RUN: begin
                    if (en) begin
                        if (wrap) begin
                            cnt  <= '0;
                            out0 <= '0;
                            out1 <= '0;
                            done <= 1'b1;
                            if (!cont) begin
                                state     <= SOBOL_IDLE;
                                out_valid <= 1'b0;
                            end
                        end else begin
                            cnt  <= cnt + 1'b1;
                            out0 <= out0 ^ v0;
                            out1 <= out1 ^ v1;
                        end
                    end
                end
                default: begin
                    state     <= SOBOL_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobol_rng_pair.sv
// Directed bench for sobol_rng_pair at WIDTH=8 with van der Corput direction vectors.
module tb_sobol_rng_pair;

    localparam int W  = 8;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          clr = 1'b0;
    logic          en = 1'b0;
    logic          cont = 1'b0;
    logic          dv_we = 1'b0;
    logic [LW-1:0] dv_addr = '0;
    logic [W:0]    dv_wdata = '0;
    logic [W-1:0]  out0;
    logic [W-1:0]  out1;
    logic          out_valid;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    sobol_rng_pair #(.WIDTH(W), .LOGWIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .en(en), .cont(cont),
        .dv_we(dv_we), .dv_addr(dv_addr), .dv_wdata(dv_wdata),
        .out0(out0), .out1(out1), .out_valid(out_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [W:0] d);
        dv_we    = 1'b1;
        dv_addr  = a[LW-1:0];
        dv_wdata = d;
        tick();
        dv_we    = 1'b0;
    endtask

    task automatic load_std();
        for (int j = 0; j < W; j++) wr(j, 9'((1 << (W - j)) | 1));
    endtask

    // Van der Corput in Gray-code order: bit-reverse of gray(n).
    function automatic logic [7:0] vdc(input int n);
        logic [7:0] g;
        logic [7:0] r;
        g = 8'(n ^ (n >> 1));
        for (int b = 0; b < 8; b++) r[7-b] = g[b];
        return r;
    endfunction

    logic [7:0] tab [8];
    bit         seen0 [256];
    bit         seen1 [256];
    int         err, done_cnt, d0, d1;

    initial begin
        tab = '{8'h00, 8'h80, 8'hC0, 8'h40, 8'h60, 8'hE0, 8'hA0, 8'h20};

        // reset state
        tick(); tick();
        chk("rst_out0", out0, 0);
        chk("rst_out1", out1, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;

        // first samples
        load_std();
        start = 1'b1; tick(); start = 1'b0;
        chk("start_valid", out_valid, 1);
        chk("start_busy", busy, 1);
        chk("start_out0", out0, 0);
        chk("start_out1", out1, 0);
        en = 1'b1;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("seq0_%0d", i), out0, tab[i]);
            chk($sformatf("seq1_%0d", i), out1, tab[i]);
        end
        en = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_valid", out_valid, 0);

        // full period, cont=0
        start = 1'b1; tick(); start = 1'b0;
        en = 1'b1; cont = 1'b0;
        err = 0; done_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (out0 !== vdc(i) || out1 !== vdc(i)) err++;
            seen0[out0] = 1'b1;
            seen1[out1] = 1'b1;
            tick();
            done_cnt += int'(done);
        end
        d0 = 0; d1 = 0;
        for (int i = 0; i < 256; i++) begin
            d0 += int'(seen0[i]);
            d1 += int'(seen1[i]);
        end
        chk("period_seq_errs", err, 0);
        chk("period_distinct0", d0, 256);
        chk("period_distinct1", d1, 256);
        chk("period_done_cnt", done_cnt, 1);
        chk("wrap_done", done, 1);
        chk("wrap_out0", out0, 0);
        chk("wrap_out1", out1, 0);
        chk("wrap_idle", out_valid, 0);
        en = 1'b0; tick();
        chk("wrap_done_drop", done, 0);

        // full period, cont=1
        start = 1'b1; tick(); start = 1'b0;
        en = 1'b1; cont = 1'b1;
        repeat (256) tick();
        chk("cont_valid", out_valid, 1);
        chk("cont_done", done, 1);
        chk("cont_out0", out0, 0);
        tick();
        chk("cont_out0_next", out0, 8'h80);
        chk("cont_done_drop", done, 0);
        en = 1'b0; cont = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;

        // en toggling
        start = 1'b1; tick(); start = 1'b0;
        en = 1'b1; tick(); chk("en_a", out0, 8'h80);
        en = 1'b0; tick(); chk("en_hold1", out0, 8'h80);
        tick(); chk("en_hold2", out0, 8'h80);
        en = 1'b1; tick();
        chk("en_b0", out0, 8'hC0);
        chk("en_b1", out1, 8'hC0);

        // write during RUN is dropped (dv[0] low bits feed channel 1 vector 7)
        en = 1'b0;
        wr(0, 9'h1FE);
        en = 1'b1;
        repeat (126) tick();
        chk("run_wr_out0", out0, 8'h03);
        chk("run_wr_out1", out1, 8'h03);

        // after clr the write commits
        en = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
        wr(0, 9'h1FE);
        start = 1'b1; tick(); start = 1'b0;
        en = 1'b1;
        repeat (127) tick();
        chk("idle_wr_out1_127", out1, 8'h02);
        tick();
        chk("idle_wr_out1_128", out1, 8'hFC);
        chk("idle_wr_out0_128", out0, 8'h03);

        // clr and start together in RUN
        en = 1'b0;
        clr = 1'b1; start = 1'b1; tick(); clr = 1'b0; start = 1'b0;
        chk("clrst_valid", out_valid, 0);
        chk("clrst_out0", out0, 0);
        chk("clrst_out1", out1, 0);
        chk("clrst_done", done, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_valid", out_valid, 1);
        chk("restart_out0", out0, 0);
        en = 1'b1; tick();
        chk("restart_out0_1", out0, 8'h80);
        tick();
        chk("restart_out0_2", out0, 8'hC0);

        // asynchronous reset mid-RUN clears dv too
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out0", out0, 0);
        chk("arst_out1", out1, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_done", done, 0);
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        en = 1'b1;
        repeat (3) tick();
        chk("noload_valid", out_valid, 1);
        chk("noload_out0", out0, 0);
        chk("noload_out1", out1, 0);
        en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
